ddr_to_image: RTL and testbench
===============================

Name: ddr_to_image

Overview:
- Read-side counterpart of the DDR frame writer.
- Fetches the most recently completed frame from the ping-pong DDR frame buffers through the FDMA read channel (reset/address/request, plus read FIFO data and empty status).
- Regenerates a video stream (field sync, valid, data) with fixed line and frame blanking.
- Sits between the video_fdma read port and downstream display/encode logic.

Parameters:
- DW, 16, pixel/data width.
- AXI_AW, 32, DDR address width.
- IMAGE_WIDTH, 640, active pixels per line.
- IMAGE_HEIGHT, 480, active lines per frame.
- HBLANK, 160, blank cycles after each active line (>=2).
- VBLANK_LINES, 20, blank lines at frame start (>=1); also the FDMA prefetch window.
- RST_PERIOD, 30, cycles o_rd_rst is held high at frame start (>=1).

Ports:
- i_Sys_clk, in, 1, single clock for all logic.
- i_Rst_n, in, 1, asynchronous active-low reset.
- i_Fix_en, in, 1, freeze: suppresses DDR reads and forces output data to zero; timing continues.
- i_Start, in, 1, one-cycle frame trigger (writer field sync).
- i_Wr_bank, in, 1, bank the writer currently fills (0 = addr1, 1 = addr2).
- i_last_addr1, in, AXI_AW, base address of bank 0.
- i_last_addr2, in, AXI_AW, base address of bank 1.
- i_rd_data, in, DW, FDMA read FIFO data, valid one cycle after o_rd_req.
- i_rd_empty, in, 1, FDMA read FIFO empty.
- o_rd_rst, out, 1, FDMA read-channel reset/start pulse.
- o_rd_addr, out, AXI_AW, frame base address for the FDMA read.
- o_rd_req, out, 1, pop one word from the read FIFO.
- o_Dout_field_sync, out, 1, high during frame reset plus vertical blank.
- o_Dout_valid, out, 1, active pixel strobe.
- o_Dout, out, DW, pixel data.
- o_Underflow, out, 1, sticky: FIFO was empty when a pixel was due.
- o_Busy, out, 1, frame in progress.

Behaviour:
- Reset (async, i_Rst_n low) forces state IDLE and all outputs 0; o_rd_addr = 0; counters = 0.
- FSM states are IDLE, FRST, VBLANK, ACTIVE.
- IDLE → FRST when i_Start=1.
  - Latch rd_bank = ~i_Wr_bank in the same cycle.
  - o_rd_addr = rd_bank ? i_last_addr2 : i_last_addr1, registered and held for the whole frame.
- FRST: o_rd_rst=1 for exactly RST_PERIOD cycles (suppressed to 0 if i_Fix_en). Then → VBLANK with hcnt=vcnt=0.
- VBLANK: counts VBLANK_LINES lines of (IMAGE_WIDTH+HBLANK) cycles each. Then → ACTIVE with hcnt=0, vcnt=0.
- ACTIVE, per line:
  - hcnt runs 0..IMAGE_WIDTH+HBLANK-1.
  - Pixel phase hcnt < IMAGE_WIDTH: internal pix_en=1.
  - At the end of a line, vcnt++.
  - After line IMAGE_HEIGHT-1 ends → IDLE (o_Busy falls the same cycle).
- o_Dout_field_sync=1 in FRST and VBLANK, 0 otherwise; registered, so it appears 1 cycle after the state is entered.
- o_rd_req = pix_en & ~i_rd_empty & ~i_Fix_en (combinational pop, same cycle as pix_en).
- Output pipeline (1-cycle latency):
  - o_Dout_valid(t+1) = pix_en(t).
  - o_Dout(t+1) = i_rd_data if o_rd_req(t) was 1, else 0.
  - The first o_Dout_valid of a line appears 1 cycle after hcnt==0.
- Underflow: if pix_en & i_rd_empty & ~i_Fix_en, then o_Underflow is set (sticky until reset). The pixel is output as 0 and timing never stalls.
- i_Start while o_Busy=1 is ignored: no restart, bank and address unchanged.
- i_Start in the same cycle as frame end (the ACTIVE→IDLE transition) is ignored. The next trigger is required.
- i_Fix_en toggling mid-frame takes effect on the next cycle. Counters and FSM are unaffected.
- o_Busy = (state != IDLE), registered.
- Counter widths: hcnt = $clog2(IMAGE_WIDTH+HBLANK); vcnt = $clog2(max(IMAGE_HEIGHT, VBLANK_LINES)+1). No wrap occurs inside a frame.

Decomposition:
- Shared package holds:
  - the FSM state encoding (IDLE, FRST, VBLANK, ACTIVE);
  - the bank-select localparams BANK0=0, BANK1=1;
  - the frame-size constant IMAGE_WIDTH*IMAGE_HEIGHT*DW/8.
- One natural sub-module, ddr_rd_timing_gen:
  - holds the hcnt/vcnt counters;
  - outputs line_end, frame_end and pix_en given the phase.
- The FSM, bank latch and data pipeline remain in ddr_to_image.

Test Plan:
Bench parameters: IMAGE_WIDTH=8, IMAGE_HEIGHT=4, HBLANK=4, VBLANK_LINES=2, RST_PERIOD=3.
1. Basic frame:
   - Stimulus: reset, i_Wr_bank=0, addr1=0x1000, addr2=0x2000, FIFO never empty with incrementing data, i_Start pulse.
   - Expect o_rd_addr=0x2000; o_rd_rst high exactly 3 cycles; field_sync high for 3+24 cycles; then 4 lines of 8 valid pixels with data 0..31, line period 12; o_Busy falls after 3+24+48 cycles; o_Underflow=0.
2. Bank swap:
   - Stimulus: i_Wr_bank=1 at the next i_Start.
   - Expect o_rd_addr=0x1000.
   - Stimulus: toggle i_Wr_bank mid-frame.
   - Expect o_rd_addr unchanged.
3. Underflow:
   - Stimulus: hold i_rd_empty=1 for pixels 2-3 of line 0.
   - Expect those o_Dout=0 with o_Dout_valid still 1, o_rd_req=0 on those cycles, o_Underflow=1 and sticky; line timing unchanged.
4. Fix enable:
   - Stimulus: i_Fix_en=1 for the whole frame.
   - Expect o_rd_rst=0, o_rd_req=0 always, o_Dout=0, o_Dout_valid pattern identical to scenario 1.
5. Busy trigger:
   - Stimulus: second i_Start during ACTIVE line 1.
   - Expect no restart; frame length is still 75 cycles.
6. Async reset:
   - Stimulus: assert i_Rst_n=0 mid-ACTIVE between clock edges.
   - Expect all outputs 0 immediately (before the next edge), state IDLE.
   - Stimulus: release, then i_Start.
   - Expect a clean full frame.

Source files
------------

// File: rtl/ddr_to_image_pkg.sv
// Shared definitions for the DDR frame reader: FSM encoding, bank selects
// and frame-size helpers.
package ddr_to_image_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FRST   = 2'd1,
    ST_VBLANK = 2'd2,
    ST_ACTIVE = 2'd3
  } state_t;

  localparam logic BANK0 = 1'b0;
  localparam logic BANK1 = 1'b1;

  localparam int unsigned DEF_IMAGE_WIDTH  = 32'd640;
  localparam int unsigned DEF_IMAGE_HEIGHT = 32'd480;
  localparam int unsigned DEF_DW           = 32'd16;
  localparam int unsigned FRAME_BYTES      = DEF_IMAGE_WIDTH * DEF_IMAGE_HEIGHT * DEF_DW / 32'd8;

  function automatic int unsigned frame_bytes(input int unsigned width,
                                              input int unsigned height,
                                              input int unsigned dw);
    return width * height * dw / 32'd8;
  endfunction

endpackage

// File: rtl/ddr_rd_timing_gen.sv
// Line/frame counters for the reader; flags line end, phase end and the
// active-pixel window while the FSM is in a counting phase.
module ddr_rd_timing_gen #(
  parameter int IMAGE_WIDTH  = 640,
  parameter int IMAGE_HEIGHT = 480,
  parameter int HBLANK       = 160,
  parameter int VBLANK_LINES = 20
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_run,
  input  logic i_active,
  output logic o_line_end,
  output logic o_frame_end,
  output logic o_pix_en
);

  localparam int LINE_LEN = IMAGE_WIDTH + HBLANK;
  localparam int HW       = $clog2(LINE_LEN);
  localparam int VMAX     = (IMAGE_HEIGHT > VBLANK_LINES) ? IMAGE_HEIGHT : VBLANK_LINES;
  localparam int VW       = $clog2(VMAX + 1);

  localparam logic [HW-1:0] H_LAST   = HW'(LINE_LEN - 1);
  localparam logic [HW-1:0] H_PIX    = HW'(IMAGE_WIDTH);
  localparam logic [VW-1:0] ACT_LAST = VW'(IMAGE_HEIGHT - 1);
  localparam logic [VW-1:0] VBL_LAST = VW'(VBLANK_LINES - 1);

  logic [HW-1:0] r_hcnt;
  logic [VW-1:0] r_vcnt;
  logic [VW-1:0] w_last_line;

  // Phase-end line index differs between vertical blank and active video.
  always_comb begin
    w_last_line = i_active ? ACT_LAST : VBL_LAST;
    o_line_end  = i_run && (r_hcnt == H_LAST);
    o_frame_end = o_line_end && (r_vcnt == w_last_line);
    o_pix_en    = i_run && i_active && (r_hcnt < H_PIX);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_hcnt <= '0;
      r_vcnt <= '0;
    end else if (!i_run) begin
      r_hcnt <= '0;
      r_vcnt <= '0;
    end else if (o_line_end) begin
      r_hcnt <= '0;
      r_vcnt <= o_frame_end ? '0 : r_vcnt + VW'(1);
    end else begin
      r_hcnt <= r_hcnt + HW'(1);
      r_vcnt <= r_vcnt;
    end
  end

endmodule

// File: rtl/ddr_to_image.sv
// Reads the last completed ping-pong frame through the FDMA read channel and
// replays it as a blanked video stream with a one-cycle output pipeline.
module ddr_to_image
  import ddr_to_image_pkg::*;
#(
  parameter int DW           = 16,
  parameter int AXI_AW       = 32,
  parameter int IMAGE_WIDTH  = 640,
  parameter int IMAGE_HEIGHT = 480,
  parameter int HBLANK       = 160,
  parameter int VBLANK_LINES = 20,
  parameter int RST_PERIOD   = 30
) (
  input  logic              i_Sys_clk,
  input  logic              i_Rst_n,
  input  logic              i_Fix_en,
  input  logic              i_Start,
  input  logic              i_Wr_bank,
  input  logic [AXI_AW-1:0] i_last_addr1,
  input  logic [AXI_AW-1:0] i_last_addr2,
  input  logic [DW-1:0]     i_rd_data,
  input  logic              i_rd_empty,
  output logic              o_rd_rst,
  output logic [AXI_AW-1:0] o_rd_addr,
  output logic              o_rd_req,
  output logic              o_Dout_field_sync,
  output logic              o_Dout_valid,
  output logic [DW-1:0]     o_Dout,
  output logic              o_Underflow,
  output logic              o_Busy
);

  localparam int RW = $clog2(RST_PERIOD + 1);
  localparam logic [RW-1:0] RST_LAST = RW'(RST_PERIOD - 1);

  state_t              r_state;
  state_t              w_next_state;
  logic [RW-1:0]       r_rst_cnt;
  logic                w_run;
  logic                w_active;
  logic                w_line_end;
  logic                w_frame_end;
  logic                w_phase_done;
  logic                w_pix_en;
  logic                w_rd_req;
  logic                w_uf_hit;
  logic                w_load;
  logic                w_rd_bank;
  logic                w_busy_d;
  logic                w_rd_rst_d;
  logic                w_fsync_d;
  logic [DW-1:0]       w_dout_d;
  logic [AXI_AW-1:0]   w_addr_d;

  logic                r_busy;
  logic                r_rd_rst;
  logic                r_fsync;
  logic                r_valid;
  logic [DW-1:0]       r_dout;
  logic                r_underflow;
  logic [AXI_AW-1:0]   r_rd_addr;

  assign w_run        = (r_state == ST_VBLANK) || (r_state == ST_ACTIVE);
  assign w_active     = (r_state == ST_ACTIVE);
  assign w_phase_done = w_line_end && w_frame_end;

  ddr_rd_timing_gen #(
    .IMAGE_WIDTH  (IMAGE_WIDTH),
    .IMAGE_HEIGHT (IMAGE_HEIGHT),
    .HBLANK       (HBLANK),
    .VBLANK_LINES (VBLANK_LINES)
  ) u_timing (
    .i_clk       (i_Sys_clk),
    .i_rst_n     (i_Rst_n),
    .i_run       (w_run),
    .i_active    (w_active),
    .o_line_end  (w_line_end),
    .o_frame_end (w_frame_end),
    .o_pix_en    (w_pix_en)
  );

  always_ff @(posedge i_Sys_clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      r_state   <= ST_IDLE;
      r_rst_cnt <= '0;
    end else begin
      r_state   <= w_next_state;
      r_rst_cnt <= (r_state == ST_FRST) ? r_rst_cnt + RW'(1) : '0;
    end
  end

  // A trigger is only honoured from IDLE, so starts during a frame or on its
  // final cycle are dropped.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE:   w_next_state = i_Start ? ST_FRST : ST_IDLE;
      ST_FRST:   w_next_state = (r_rst_cnt == RST_LAST) ? ST_VBLANK : ST_FRST;
      ST_VBLANK: w_next_state = w_phase_done ? ST_ACTIVE : ST_VBLANK;
      ST_ACTIVE: w_next_state = w_phase_done ? ST_IDLE : ST_ACTIVE;
      default:   w_next_state = ST_IDLE;
    endcase
  end

  always_comb begin
    w_load     = (r_state == ST_IDLE) && i_Start;
    w_rd_bank  = ~i_Wr_bank;
    w_addr_d   = r_rd_addr;
    if (w_load) begin
      w_addr_d = (w_rd_bank == BANK1) ? i_last_addr2 : i_last_addr1;
    end else begin
      w_addr_d = r_rd_addr;
    end
    w_busy_d   = (w_next_state != ST_IDLE);
    w_rd_rst_d = (w_next_state == ST_FRST) && !i_Fix_en;
    w_fsync_d  = (r_state == ST_FRST) || (r_state == ST_VBLANK);
    w_rd_req   = w_pix_en && !i_rd_empty && !i_Fix_en;
    w_uf_hit   = w_pix_en && i_rd_empty && !i_Fix_en;
    w_dout_d   = w_rd_req ? i_rd_data : '0;
  end

  always_ff @(posedge i_Sys_clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      r_busy      <= 1'b0;
      r_rd_rst    <= 1'b0;
      r_fsync     <= 1'b0;
      r_valid     <= 1'b0;
      r_dout      <= '0;
      r_underflow <= 1'b0;
      r_rd_addr   <= '0;
    end else begin
      r_busy      <= w_busy_d;
      r_rd_rst    <= w_rd_rst_d;
      r_fsync     <= w_fsync_d;
      r_valid     <= w_pix_en;
      r_dout      <= w_dout_d;
      r_underflow <= r_underflow | w_uf_hit;
      r_rd_addr   <= w_addr_d;
    end
  end

  assign o_rd_req          = w_rd_req;
  assign o_rd_rst          = r_rd_rst;
  assign o_rd_addr         = r_rd_addr;
  assign o_Dout_field_sync = r_fsync;
  assign o_Dout_valid      = r_valid;
  assign o_Dout            = r_dout;
  assign o_Underflow       = r_underflow;
  assign o_Busy            = r_busy;

endmodule

// File: tb/tb_ddr_to_image.sv
// Directed bench for ddr_to_image with a small frame geometry; each frame is
// checked cycle by cycle against a timeline computed here.
module tb_ddr_to_image;

  localparam int DW  = 16;
  localparam int AW  = 32;
  localparam int W   = 8;
  localparam int H   = 4;
  localparam int HB  = 4;
  localparam int VB  = 2;
  localparam int RP  = 3;
  localparam int LL  = W + HB;
  localparam int ACT0 = RP + VB * LL;
  localparam int FEND = ACT0 + H * LL;

  logic          clk = 1'b0;
  logic          i_Rst_n;
  logic          i_Fix_en;
  logic          i_Start;
  logic          i_Wr_bank;
  logic [AW-1:0] i_last_addr1;
  logic [AW-1:0] i_last_addr2;
  logic [DW-1:0] i_rd_data;
  logic          i_rd_empty;
  logic          o_rd_rst;
  logic [AW-1:0] o_rd_addr;
  logic          o_rd_req;
  logic          o_Dout_field_sync;
  logic          o_Dout_valid;
  logic [DW-1:0] o_Dout;
  logic          o_Underflow;
  logic          o_Busy;

  logic [DW-1:0] fifo_cnt = 16'd0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (o_rd_req) fifo_cnt <= fifo_cnt + 16'd1;
  end

  assign i_rd_data = fifo_cnt;

  ddr_to_image #(
    .DW(DW), .AXI_AW(AW), .IMAGE_WIDTH(W), .IMAGE_HEIGHT(H),
    .HBLANK(HB), .VBLANK_LINES(VB), .RST_PERIOD(RP)
  ) dut (
    .i_Sys_clk(clk), .i_Rst_n(i_Rst_n), .i_Fix_en(i_Fix_en), .i_Start(i_Start),
    .i_Wr_bank(i_Wr_bank), .i_last_addr1(i_last_addr1), .i_last_addr2(i_last_addr2),
    .i_rd_data(i_rd_data), .i_rd_empty(i_rd_empty), .o_rd_rst(o_rd_rst),
    .o_rd_addr(o_rd_addr), .o_rd_req(o_rd_req), .o_Dout_field_sync(o_Dout_field_sync),
    .o_Dout_valid(o_Dout_valid), .o_Dout(o_Dout), .o_Underflow(o_Underflow), .o_Busy(o_Busy)
  );

  typedef struct {
    logic          wr_bank;
    logic          fix;
    int            empty_lo;
    int            empty_hi;
    int            start2;
    int            toggle;
    logic [AW-1:0] exp_addr;
  } vec_t;

  vec_t vecs[6];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic check(input string nm, input int c, input logic [AW-1:0] act,
                       input logic [AW-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got 0x%0h expected 0x%0h", nm, c, act, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_rd_rst"}, -1, {31'd0, o_rd_rst}, 32'd0);
    check({tag, "_rd_addr"}, -1, o_rd_addr, 32'd0);
    check({tag, "_rd_req"}, -1, {31'd0, o_rd_req}, 32'd0);
    check({tag, "_fsync"}, -1, {31'd0, o_Dout_field_sync}, 32'd0);
    check({tag, "_valid"}, -1, {31'd0, o_Dout_valid}, 32'd0);
    check({tag, "_dout"}, -1, {16'd0, o_Dout}, 32'd0);
    check({tag, "_underflow"}, -1, {31'd0, o_Underflow}, 32'd0);
    check({tag, "_busy"}, -1, {31'd0, o_Busy}, 32'd0);
  endtask

  task automatic do_reset();
    i_Rst_n    = 1'b0;
    i_Start    = 1'b0;
    i_Fix_en   = 1'b0;
    i_rd_empty = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset");
    i_Rst_n = 1'b1;
    @(negedge clk);
  endtask

  // Called at a negedge; triggers a frame and checks FEND+5 cycles.
  task automatic run_frame(input vec_t v, input bit do_rst);
    logic [DW-1:0] base;
    int   exp_n;
    logic e_uf, prev_pix, prev_req, pix, e_req, empty;
    logic [DW-1:0] prev_data;
    if (do_rst) do_reset();
    i_Wr_bank  = v.wr_bank;
    i_Fix_en   = v.fix;
    i_rd_empty = 1'b0;
    i_Start    = 1'b1;
    base      = fifo_cnt;
    exp_n     = 0;
    e_uf      = 1'b0;
    prev_pix  = 1'b0;
    prev_req  = 1'b0;
    prev_data = 16'd0;
    @(posedge clk);
    for (int c = 0; c < FEND + 5; c++) begin
      @(negedge clk);
      i_Start    = (c == v.start2);
      empty      = (c >= v.empty_lo) && (c <= v.empty_hi);
      i_rd_empty = empty;
      if (c == v.toggle) i_Wr_bank = ~v.wr_bank;
      #1;
      pix   = (c >= ACT0) && (c < FEND) && (((c - ACT0) % LL) < W);
      e_req = pix && !empty && !v.fix;
      check("busy", c, {31'd0, o_Busy}, {31'd0, (c < FEND)});
      check("rd_rst", c, {31'd0, o_rd_rst}, {31'd0, (c < RP) && !v.fix});
      check("fsync", c, {31'd0, o_Dout_field_sync}, {31'd0, (c >= 1) && (c <= ACT0)});
      check("rd_addr", c, o_rd_addr, v.exp_addr);
      check("valid", c, {31'd0, o_Dout_valid}, {31'd0, prev_pix});
      check("dout", c, {16'd0, o_Dout}, {16'd0, (prev_req ? prev_data : 16'd0)});
      check("rd_req", c, {31'd0, o_rd_req}, {31'd0, e_req});
      check("underflow", c, {31'd0, o_Underflow}, {31'd0, e_uf});
      if (pix && empty && !v.fix) e_uf = 1'b1;
      prev_pix  = pix;
      prev_req  = e_req;
      prev_data = base + DW'(exp_n);
      if (e_req) exp_n++;
    end
    i_Start    = 1'b0;
    i_rd_empty = 1'b0;
  endtask

  initial begin
    i_Rst_n      = 1'b0;
    i_Fix_en     = 1'b0;
    i_Start      = 1'b0;
    i_Wr_bank    = 1'b0;
    i_rd_empty   = 1'b0;
    i_last_addr1 = 32'h0000_1000;
    i_last_addr2 = 32'h0000_2000;

    //          bank  fix   emp_lo       emp_hi       start2     toggle     addr
    vecs[0] = '{1'b0, 1'b0, -1,          -1,          -1,        -1,        32'h2000};
    vecs[1] = '{1'b1, 1'b0, -1,          -1,          -1,        40,        32'h1000};
    vecs[2] = '{1'b0, 1'b0, ACT0 + 2,    ACT0 + 3,    -1,        -1,        32'h2000};
    vecs[3] = '{1'b0, 1'b1, -1,          -1,          -1,        -1,        32'h2000};
    vecs[4] = '{1'b0, 1'b0, -1,          -1,          ACT0 + LL + 2, -1,    32'h2000};
    vecs[5] = '{1'b1, 1'b0, -1,          -1,          FEND - 1,  -1,        32'h1000};

    @(negedge clk);
    for (int i = 0; i < 6; i++) begin
      run_frame(vecs[i], 1'b1);
    end

    // Async reset mid-ACTIVE, asserted between clock edges.
    do_reset();
    i_Wr_bank = 1'b0;
    i_Start   = 1'b1;
    @(negedge clk);
    i_Start = 1'b0;
    repeat (ACT0 + LL + 3) @(negedge clk);
    check("pre_reset_busy", -1, {31'd0, o_Busy}, 32'd1);
    #2;
    i_Rst_n = 1'b0;
    #1;
    check_all_zero("async");
    @(negedge clk);
    i_Rst_n = 1'b1;
    @(negedge clk);
    run_frame(vecs[0], 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
